// File: rtl/cmd_ram_dp.sv
// Single-clock simple dual-port RAM for command/symbol buffers: masked writes,
// selectable read-during-write, optional output register and a clear sweeper.
module cmd_ram_dp #(
    parameter int                  DATA_W     = 16,
    parameter int                  DEPTH      = 2048,
    parameter int                  ADDR_W     = $clog2(DEPTH),
    parameter int                  OUT_REG    = 0,
    parameter int                  RDW_MODE   = 0,
    parameter logic [DATA_W-1:0]   INIT_VALUE = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    output logic              busy_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                waddr_ok, raddr_ok;
    logic                wr_en, rd_en;
    logic [DATA_W-1:0]   wr_old, wr_merged, rd_word;
    logic [DATA_W-1:0]   rd1_q;
    logic                rv1_q;

    assign busy_o   = (state_q == ST_CLEAR);
    assign waddr_ok = ({1'b0, waddr_i} < DEPTH_X);
    assign raddr_ok = ({1'b0, raddr_i} < DEPTH_X);
    assign wr_en    = !busy_o && we_i && waddr_ok;
    assign rd_en    = !busy_o && re_i;

    // Masked bits keep the stored value; the merge is done in the write cycle.
    always_comb begin
        wr_old    = waddr_ok ? mem[waddr_i] : '0;
        wr_merged = (wr_old & mask_i) | (wdata_i & ~mask_i);
    end

    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            if ((RDW_MODE != 0) && wr_en && (waddr_i == raddr_i)) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[raddr_i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array itself has no reset; the sweep after reset initialises it.
    always_ff @(posedge clk_i) begin
        if (busy_o) begin
            mem[cnt_q] <= INIT_VALUE;
        end else if (wr_en) begin
            mem[waddr_i] <= wr_merged;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd1_q <= '0;
            rv1_q <= 1'b0;
        end else begin
            rv1_q <= rd_en;
            if (rd_en) begin
                rd1_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rd2_q;
            logic              rv2_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    rd2_q <= '0;
                    rv2_q <= 1'b0;
                end else begin
                    rv2_q <= rv1_q;
                    if (rv1_q) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign rdata_o  = rd2_q;
            assign rvalid_o = rv2_q;
        end else begin : g_no_out_reg
            assign rdata_o  = rd1_q;
            assign rvalid_o = rv1_q;
        end
    endgenerate

endmodule

// File: tb/tb_cmd_ram_dp.sv
// Bench for cmd_ram_dp: two builds (2048-deep, latency 1, old-data RDW, init 0
// and 1000-deep, latency 2, new-data RDW, init C3C3) checked against a model.
module tb_cmd_ram_dp;

    logic        clk = 1'b0;
    logic        rst_n  [2];
    logic        clr    [2];
    logic        we     [2];
    logic        re     [2];
    logic [10:0] waddr  [2];
    logic [10:0] raddr  [2];
    logic [15:0] wdata  [2];
    logic [15:0] mask   [2];
    logic [15:0] rdata  [2];
    logic        busy   [2];
    logic        rvalid [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          dut;
        int          addr;
        logic [15:0] data;
        int          cyc;
    } rd_t;

    rd_t         sb [$];
    logic [15:0] model [2][2048];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_ram_dp #(
        .DATA_W(16), .DEPTH(2048), .OUT_REG(0), .RDW_MODE(0), .INIT_VALUE(16'h0000)
    ) dut0 (
        .clk_i(clk), .rst_n_i(rst_n[0]), .clr_i(clr[0]), .busy_o(busy[0]),
        .we_i(we[0]), .waddr_i(waddr[0]), .wdata_i(wdata[0]), .mask_i(mask[0]),
        .re_i(re[0]), .raddr_i(raddr[0]), .rdata_o(rdata[0]), .rvalid_o(rvalid[0])
    );

    cmd_ram_dp #(
        .DATA_W(16), .DEPTH(1000), .OUT_REG(1), .RDW_MODE(1), .INIT_VALUE(16'hC3C3)
    ) dut1 (
        .clk_i(clk), .rst_n_i(rst_n[1]), .clr_i(clr[1]), .busy_o(busy[1]),
        .we_i(we[1]), .waddr_i(waddr[1][9:0]), .wdata_i(wdata[1]), .mask_i(mask[1]),
        .re_i(re[1]), .raddr_i(raddr[1][9:0]), .rdata_o(rdata[1]), .rvalid_o(rvalid[1])
    );

    function automatic int dep(int d);
        return (d == 0) ? 2048 : 1000;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit rdw(int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [15:0] initv(int d);
        return (d == 0) ? 16'h0000 : 16'hC3C3;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(int d);
        for (int a = 0; a < dep(d); a++) model[d][a] = initv(d);
    endtask

    // Drive one cycle of stimulus (called at a falling edge) and update the model.
    task automatic step(int d, bit w, int wa, logic [15:0] wd, logic [15:0] mk,
                        bit r, int ra, bit c);
        logic [15:0] expv;
        we[d]    = w;
        waddr[d] = 11'(wa);
        wdata[d] = wd;
        mask[d]  = mk;
        re[d]    = r;
        raddr[d] = 11'(ra);
        clr[d]   = c;
        if (r) begin
            if (ra >= dep(d))
                expv = 16'h0000;
            else if (w && wa == ra && rdw(d))
                expv = (model[d][ra] & mk) | (wd & ~mk);
            else
                expv = model[d][ra];
            sb.push_back('{d, ra, expv, cyc + lat(d)});
        end
        if (w && wa < dep(d)) model[d][wa] = (model[d][wa] & mk) | (wd & ~mk);
        if (c) fill(d);
        @(negedge clk);
        we[d]  = 1'b0;
        re[d]  = 1'b0;
        clr[d] = 1'b0;
    endtask

    task automatic wr(int d, int a, logic [15:0] v, logic [15:0] m);
        step(d, 1'b1, a, v, m, 1'b0, 0, 1'b0);
    endtask

    task automatic rd(int d, int a);
        step(d, 1'b0, 0, 16'h0, 16'h0, 1'b1, a, 1'b0);
    endtask

    task automatic idle(int d, int n);
        repeat (n) step(d, 1'b0, 0, 16'h0, 16'h0, 1'b0, 0, 1'b0);
    endtask

    // Counts BUSY cycles while hammering RE (must be ignored); optional CLR at 'mid'.
    task automatic sweep(int d, int mid, output int n);
        n = 0;
        fill(d);
        while (busy[d] === 1'b1 && n < 5000) begin
            re[d]    = 1'b1;
            raddr[d] = 11'd0;
            clr[d]   = (n == mid);
            n++;
            @(negedge clk);
        end
        re[d]  = 1'b0;
        clr[d] = 1'b0;
    endtask

    always @(posedge clk) begin
        rd_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dut != d) begin
                    chk("unexpected_rvalid", {31'b0, rvalid[d]}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("rd dut%0d addr=%0d data=%h exp=%h cyc=%0d",
                             d, e.addr, rdata[d], e.data, cyc);
                    chk("rdata", {16'b0, rdata[d]}, {16'b0, e.data});
                    chk("rd_latency", cyc, e.cyc);
                end
            end
        end
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missing_rvalid", {31'b0, rvalid[e.dut]}, 32'd1);
        end
    end

    task automatic run_suite(int d);
        int n;
        int last;
        last = dep(d) - 1;

        rst_n[d] = 1'b1;
        sweep(d, -1, n);
        chk("init_busy_cycles", n, dep(d));
        chk("rvalid_after_sweep", {31'b0, rvalid[d]}, 32'd0);
        rd(d, last);
        idle(d, 3);

        wr(d, 5, 16'hABCD, 16'h0000);
        wr(d, 5, 16'h1234, 16'hFF00);
        rd(d, 5);
        idle(d, 3);

        wr(d, 9, 16'h0001, 16'h0000);
        step(d, 1'b1, 9, 16'h00F0, 16'h0000, 1'b1, 9, 1'b0);
        rd(d, 9);
        step(d, 1'b1, 9, 16'hFFFF, 16'hFFFF, 1'b1, 9, 1'b0);
        step(d, 1'b1, 9, 16'hABCD, 16'h0F0F, 1'b1, 9, 1'b0);
        rd(d, 9);
        idle(d, 3);

        for (int i = 0; i < 4; i++) wr(d, i, 16'(16'h10 + i), 16'h0000);
        for (int i = 0; i < 4; i++) rd(d, i);
        idle(d, 3);
        chk("rdata_hold", {16'b0, rdata[d]}, 32'h13);
        chk("rvalid_idle", {31'b0, rvalid[d]}, 32'd0);

        step(d, 1'b1, 20, 16'h7777, 16'h0000, 1'b1, 3, 1'b0);
        rd(d, 20);
        idle(d, 3);

        wr(d, 1000, 16'hDEAD, 16'h0000);
        rd(d, 1000);
        wr(d, 999, 16'h9999, 16'h0000);
        rd(d, 999);
        rd(d, 0);
        idle(d, 3);

        wr(d, 7, 16'h5A5A, 16'h0000);
        rd(d, 7);
        idle(d, 3);
        wr(d, 100, 16'hFFFF, 16'h0000);
        step(d, 1'b1, 101, 16'h1111, 16'h0000, 1'b0, 0, 1'b1);
        sweep(d, 500, n);
        chk("clr_busy_cycles", n, dep(d));
        chk("rdata_hold_busy", {16'b0, rdata[d]}, 32'h5A5A);
        rd(d, 100);
        rd(d, 101);
        idle(d, 3);

        wr(d, 7, 16'h5A5A, 16'h0000);
        rd(d, 7);
        idle(d, 3);
        step(d, 1'b0, 0, 16'h0, 16'h0, 1'b0, 0, 1'b1);
        idle(d, 300);
        rst_n[d] = 1'b0;
        #1;
        chk("rst_rdata", {16'b0, rdata[d]}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid[d]}, 32'd0);
        chk("rst_busy", {31'b0, busy[d]}, 32'd1);
        @(negedge clk);
        rst_n[d] = 1'b1;
        sweep(d, -1, n);
        chk("rst_busy_cycles", n, dep(d));
        rd(d, 7);
        idle(d, 4);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            clr[d]   = 1'b0;
            we[d]    = 1'b0;
            re[d]    = 1'b0;
            waddr[d] = '0;
            raddr[d] = '0;
            wdata[d] = '0;
            mask[d]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_rdata", {16'b0, rdata[d]}, 32'h0);
            chk("reset_rvalid", {31'b0, rvalid[d]}, 32'd0);
            chk("reset_busy", {31'b0, busy[d]}, 32'd1);
        end
        run_suite(0);
        run_suite(1);
        idle(0, 5);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_ram_dp.md
Name: cmd_ram_dp

Overview:
- Parametrised single-clock, simple dual-port RAM (one write port, one read port) for graphics command and symbol buffers; successor to the fixed 2048x16 block RAM model.
- Adds: parametrised width and depth; true bit-masked writes, where masked bits keep their old contents; selectable read-during-write behaviour; optional output register with a read-valid strobe; hardware clear sequencer that sweeps the array to INIT_VALUE after reset or on request.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 2048, number of words; need not be a power of 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
- RDW_MODE, 0, same-address read and write in one cycle: 0 = read returns old data; 1 = read returns newly written (merged) data.
- INIT_VALUE, '0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- CLK  in  1  single clock for all logic.
- RST_N  in  1  asynchronous active-low reset.
- CLR  in  1  pulse: request a full-array clear.
- BUSY  out  1  high while the clear sequencer runs.
- WE  in  1  write enable.
- WADDR  in  ADDR_W  write address.
- WDATA  in  DATA_W  write data.
- MASK  in  DATA_W  per-bit write mask; 1 = bit not written (old value kept).
- RE  in  1  read enable.
- RADDR  in  ADDR_W  read address.
- RDATA  out  DATA_W  read data.
- RVALID  out  1  high for one cycle when RDATA carries the result of an accepted read.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Outputs: RDATA=0, RVALID=0, pipeline registers cleared.
  - FSM forced to CLEAR, sweep counter=0, BUSY=1.
  - Array contents are not reset directly; the clear sweep handles them.
- FSM states:
  - CLEAR: each cycle writes INIT_VALUE to address cnt, then cnt++. After writing DEPTH-1, go to READY on the next edge; BUSY drops in that cycle. A clear takes exactly DEPTH cycles.
  - READY: normal operation. CLR=1 here sets cnt=0 and goes to CLEAR next cycle.
  - CLR while already in CLEAR is ignored; the sweep is not restarted.
  - Reset asserted mid-sweep restarts the sweep from 0.
- While BUSY=1: WE and RE are ignored. No writes or reads are accepted, RVALID stays 0, RDATA holds its value.
- Write (READY, WE=1, WADDR<DEPTH): on the clock edge, mem[WADDR] <= (mem[WADDR] & MASK) | (WDATA & ~MASK).
  - Read-modify-write is internal and single-cycle.
  - MASK all-ones means no change.
- Read (READY, RE=1):
  - OUT_REG=0: RDATA and RVALID update on the same edge that samples RADDR, so data is visible 1 cycle after RE.
  - OUT_REG=1: one more register stage; 2-cycle latency; RVALID follows the same pipeline.
  - RE=0: RVALID=0 and RDATA holds its last value.
  - Fully pipelined: one read accepted per cycle, back-to-back.
- Same-address read and write in one cycle: RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns the merged post-write word.
  - The mask applies to the forwarded value.
- Out-of-range addresses (non-power-of-2 DEPTH):
  - A write with WADDR>=DEPTH is dropped.
  - A read with RADDR>=DEPTH returns 0 with RVALID=1.
- Simultaneous write and read to different addresses are independent.
- CLR and WE in the same READY cycle: the write completes, then the clear overwrites it.

Test Plan:
- Reset, then observe BUSY → BUSY=1 for exactly DEPTH cycles (2048). Reads issued during the sweep give RVALID=0. After BUSY falls, a read of addr 0x7FF returns INIT_VALUE (0x0000).
- Write 0xABCD to addr 5 with MASK=0, then write 0x1234 to addr 5 with MASK=0xFF00. Read addr 5 → 0xAB34, with RVALID one cycle after RE (OUT_REG=0) or two cycles after (OUT_REG=1).
- Same-cycle read and write to addr 9: old=0x0001, WDATA=0x00F0, MASK=0. Expect RDATA=0x0001 with RDW_MODE=0 and 0x00F0 with RDW_MODE=1.
- Back-to-back reads of addrs 0..3 holding 0x10..0x13 over 4 cycles → RDATA sequence 0x10,0x11,0x12,0x13 on consecutive cycles, RVALID held high 4 cycles.
- Pulse CLR after writing 0xFFFF to addr 100 → BUSY=1 for DEPTH cycles, a second CLR mid-sweep does not extend it, and addr 100 then reads INIT_VALUE. Assert RST_N low mid-sweep → RDATA=0 immediately and the sweep restarts from 0.
- DEPTH=1000 build: write to addr 1000 is dropped, and a read of addr 1000 → RDATA=0 with RVALID=1. Addr 999 reads and writes normally.
